// File: rtl/rr_sch_pkt.sv
// Packet-aware round-robin arbiter: N requesters onto one output, registered one-hot/binary grant.
// Define RR_SCH_WRR_EN to add per-port weighted credits (extra consecutive grants).
module rr_sch_pkt #(
  parameter int NUM_PORT     = 4,
  parameter int LOG_NUM_PORT = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1,
  parameter int PKT_MODE     = 1,
  parameter int W_BITS       = 3
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [NUM_PORT-1:0]        req,
  input  logic [NUM_PORT-1:0]        req_last,
  input  logic                       ack,
  input  logic [NUM_PORT*W_BITS-1:0] weight,
  output logic [NUM_PORT-1:0]        grant,
  output logic                       grant_valid,
  output logic [LOG_NUM_PORT-1:0]    grant_index
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [LOG_NUM_PORT-1:0] ptr;
  logic [LOG_NUM_PORT-1:0] ptr_adv;
  logic [LOG_NUM_PORT-1:0] start;
  logic [LOG_NUM_PORT-1:0] win_idx;
  logic [NUM_PORT-1:0]     cand;
  logic                    win_found;
  logic                    own_req;
  logic                    own_last;
  logic                    rel;
  logic                    abort;
  logic                    done;
  logic                    keep;

  // Circular scan from start; wrap is modulo NUM_PORT, not the index width.
  function automatic logic [LOG_NUM_PORT:0] pick(input logic [NUM_PORT-1:0]     c,
                                                 input logic [LOG_NUM_PORT-1:0] s);
    logic                    found;
    logic [LOG_NUM_PORT-1:0] idx;
    int                      p;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      p = int'(s) + k;
      if (p >= NUM_PORT) p = p - NUM_PORT;
      if (!found && ((c & (NUM_PORT'(1) << p)) != '0)) begin
        found = 1'b1;
        idx   = LOG_NUM_PORT'(p);
      end
    end
    return {found, idx};
  endfunction

`ifdef RR_SCH_WRR_EN
  logic [W_BITS-1:0] credit;

  function automatic logic [W_BITS-1:0] wsel(input logic [LOG_NUM_PORT-1:0] idx);
    logic [W_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_PORT; i++)
      if (LOG_NUM_PORT'(i) == idx) w = weight[i*W_BITS +: W_BITS];
    return w;
  endfunction
`else
  logic unused_weight;
  assign unused_weight = ^weight;
`endif

  always_comb begin
    own_req  = |(req & grant);
    own_last = |(req_last & grant);
    rel      = ack && ((PKT_MODE == 0) || own_last);
    abort    = !own_req && !ack;
    done     = (state == BUSY) && (rel || abort);
    ptr_adv  = (grant_index == LOG_NUM_PORT'(NUM_PORT - 1)) ? '0 : grant_index + 1'b1;
    // After a release the outgoing owner is masked so another port gets a turn.
    cand     = (state == IDLE) ? req : (req & ~grant);
    start    = (state == IDLE) ? ptr : ptr_adv;
    {win_found, win_idx} = pick(cand, start);
`ifdef RR_SCH_WRR_EN
    keep     = done && rel && own_req && (credit != '0);
`else
    keep     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
`ifdef RR_SCH_WRR_EN
      credit      <= '0;
`endif
    end else if ((state == IDLE && win_found) || (done && !keep && win_found)) begin
      if (state == BUSY) ptr <= ptr_adv;
      state       <= BUSY;
      grant       <= NUM_PORT'(1) << win_idx;
      grant_valid <= 1'b1;
      grant_index <= win_idx;
`ifdef RR_SCH_WRR_EN
      credit      <= wsel(win_idx);
`endif
    end else if (done && !keep) begin
      ptr         <= ptr_adv;
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
`ifdef RR_SCH_WRR_EN
      credit      <= '0;
`endif
    end else if (keep) begin
`ifdef RR_SCH_WRR_EN
      // Same owner keeps the output for another beat/packet; pointer stays put.
      credit      <= credit - 1'b1;
`endif
    end
  end

endmodule

// File: doc/rr_sch_pkt.md
Name: rr_sch_pkt

Overview:
- Parametrised packet-aware round-robin arbiter; successor to the fixed 4-port scheduler in the GSM switch.
- Arbitrates N input queues onto one crossbar output port.
- Supports any port count, registered one-hot and binary grants, and an ack handshake.
- Optionally holds the grant for a whole multi-beat packet, with weighted credits behind a macro.

Parameters:
- NUM_PORT, 4, number of requesters; any value >= 2, need not be a power of 2.
- LOG_NUM_PORT, clog2(NUM_PORT) (min 1), width of grant_index and pointer.
- PKT_MODE, 1, 1 = grant held until last beat acked; 0 = grant released after every acked beat.
- W_BITS, 3, per-port weight width (used only with RR_SCH_WRR_EN).

Ports:
- clk  in  1  clock; all logic on posedge.
- clr  in  1  synchronous active-high reset.
- req  in  NUM_PORT  per-port request; level, held until granted beat acked.
- req_last  in  NUM_PORT  per-port end-of-packet flag for current beat (PKT_MODE=1 only).
- ack  in  1  downstream accepts current granted beat this cycle.
- weight  in  NUM_PORT*W_BITS  per-port extra consecutive grants; port i at [i*W_BITS +: W_BITS]; ignored without macro.
- grant  out  NUM_PORT  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  registered; equals |grant.
- grant_index  out  LOG_NUM_PORT  registered binary index of grant; 0 when idle.

Behaviour:
- Reset (clr=1 at a clock edge, overrides everything):
  - grant=0, grant_valid=0, grant_index=0.
  - Pointer ptr=0, so port 0 has top priority first; state IDLE; credit=0.
- Selection, combinational:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... NUM_PORT-1, 0, ... ptr-1.
  - Wrap is modulo NUM_PORT, not 2^LOG_NUM_PORT.
- States: IDLE, BUSY.
- IDLE:
  - If |req, register the winner: grant, grant_index, grant_valid=1, go BUSY.
  - Latency is 1 cycle from req to grant.
  - Otherwise stay IDLE with outputs 0.
- BUSY, owner g:
  - Beat completes when ack=1.
  - Release condition: ack && (PKT_MODE==0 || req_last[g]).
  - Abort condition: req[g]=0 with ack=0; treated as a release, no protocol error.
  - No release: grant held unchanged regardless of other requests.
  - On release: ptr <= (g+1) mod NUM_PORT.
  - In the same cycle, the next winner is selected using the new ptr and the current req with bit g masked.
  - If a winner exists, it is registered and the state stays BUSY (back-to-back, zero bubble). Otherwise, IDLE with outputs cleared.
  - If only port g requests, masking leaves no winner: one idle cycle, then g is re-granted.
- ack while grant_valid=0 is ignored.
- req for a non-owner port changing during BUSY has no effect until release.
- grant is never multi-hot; grant_index always matches grant.

Optional Feature:
- Macro: RR_SCH_WRR_EN.
- Defined:
  - On a fresh grant to port g (ptr advanced), credit <= weight[g].
  - On release with credit>0 and req[g]=1 (next packet/beat pending), g is re-granted next cycle without masking, credit <= credit-1, ptr unchanged.
  - On release with credit=0 or req[g]=0, normal advance.
  - Abort clears credit.
  - Weight 0 gives plain round robin.
- Undefined: weight input unused, credit register absent; plain round robin.

Test Plan:
- NUM_PORT=4, PKT_MODE=0, req=4'b1111 held, ack=1 from cycle 1 → grant_index 0,1,2,3,0,1 on consecutive cycles, grant_valid continuously 1 after first grant.
- PKT_MODE=1, req=4'b0110, port1 sends 3-beat packet, ack pattern 1,0,1,1 with req_last[1] on beat 3 → grant=4'b0010 held 4 cycles, then 4'b0100 the next cycle.
- Sparse req=4'b0101 held, ack=1, PKT_MODE=0 → grants alternate 0,2,0,2; port 1/3 never granted.
- NUM_PORT=5, req=5'b10001, ack=1 → grant_index 0,4,0,4; verifies modulo-5 wrap.
- clr asserted mid-packet (port 2 owner) → next cycle grant=0, grant_valid=0; with req=4'b1100, first grant after clr is port 2 (ptr=0).
- RR_SCH_WRR_EN, weight[0]=2, others 0, req=4'b0011 held, PKT_MODE=0, ack=1 → grant_index sequence 0,0,0,1,0,0,0,1.
